// File: rtl/regfile_sweep.sv
// ---------------------------------------------------------------------------
// regfile_sweep
//   Parametrised 2-read / 1-write register file with registered reads, an
//   optional write-to-read bypass and an optional hardwired zero entry.
//   The storage array carries no reset. It is zeroed by a sequential clear
//   engine that handles one entry per cycle, so the array stays RAM-inferable.
//   A sweep runs after every reset and whenever clr_req_i is seen in IDLE.
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_i        asynchronous active-high reset (starts a clear sweep)
//   clr_req_i    request a full clear sweep (honoured in IDLE only)
//   busy_o       high while a clear sweep is in progress
//   rd_addr1_i   read port 1 address
//   rd_addr2_i   read port 2 address
//   rd_data1_o   registered read data, port 1 (1-cycle latency)
//   rd_data2_o   registered read data, port 2 (1-cycle latency)
//   we_i         write enable
//   wr_addr_i    write address
//   wr_data_i    write data
//   wr_err_o     1-cycle pulse: a requested write was dropped
// ---------------------------------------------------------------------------
module regfile_sweep #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_req_i,
    output logic             busy_o,
    input  logic [AW-1:0]    rd_addr1_i,
    input  logic [AW-1:0]    rd_addr2_i,
    output logic [WIDTH-1:0] rd_data1_o,
    output logic [WIDTH-1:0] rd_data2_o,
    input  logic             we_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_err_o
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    // One extra bit so addresses can be compared against DEPTH even when
    // DEPTH is an exact power of two.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state_q;
    logic [AW-1:0]    ptr_q;
    logic             busy_q;
    logic             wr_err_q;
    logic [WIDTH-1:0] rd_data1_q, rd_data2_q;
    logic [WIDTH-1:0] rd_data1_d, rd_data2_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic in_clear;
    logic wr_in_range;
    logic wr_acc;
    logic wr_drop;

    assign in_clear    = (state_q == S_CLEAR);
    assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_W);
    // Writes to the zero entry vanish silently; only out-of-range writes or
    // writes during a sweep are reported as errors.
    assign wr_acc      = !in_clear && we_i && wr_in_range
                         && !(ZERO_REG && (wr_addr_i == '0));
    assign wr_drop     = we_i && (in_clear || !wr_in_range);

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] v;
        v = '0;
        if (in_clear || ({1'b0, addr} >= DEPTH_W) || (ZERO_REG && (addr == '0)))
            v = '0;
        else if (BYPASS && wr_acc && (wr_addr_i == addr))
            v = wr_data_i;
        else
            v = mem[addr];
        return v;
    endfunction

    always_comb begin
        rd_data1_d = read_port(rd_addr1_i);
        rd_data2_d = read_port(rd_addr2_i);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            wr_err_q   <= 1'b0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else begin
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            wr_err_q   <= wr_drop;
            case (state_q)
                S_CLEAR: begin
                    if (ptr_q == LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                S_IDLE: begin
                    if (clr_req_i) begin
                        state_q <= S_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage: no reset. Any write that raced a reset is wiped by the sweep
    // that the reset starts.
    always_ff @(posedge clk_i) begin
        if (in_clear)
            mem[ptr_q] <= '0;
        else if (wr_acc)
            mem[wr_addr_i] <= wr_data_i;
    end

    assign busy_o     = busy_q;
    assign wr_err_o   = wr_err_q;
    assign rd_data1_o = rd_data1_q;
    assign rd_data2_o = rd_data2_q;

endmodule

// File: tb/tb_regfile_sweep.sv
// ---------------------------------------------------------------------------
// tb_regfile_sweep
//   Two instances share one stimulus stream:
//     [0] DEPTH=8, ZERO_REG=1, BYPASS=1
//     [1] DEPTH=6, ZERO_REG=0, BYPASS=0
//   A behavioural model (plain arrays plus a "cycles of clearing left"
//   counter) predicts every output every cycle. A directed table and
//   hand-written reset/clear sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_regfile_sweep;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       we  = 1'b0;
    logic [2:0] wa  = '0;
    logic [2:0] ra1 = '0;
    logic [2:0] ra2 = '0;
    logic [7:0] wd  = '0;

    logic       busy_a, busy_b, err_a, err_b;
    logic [7:0] r1_a, r2_a, r1_b, r2_b;

    always #5 clk = ~clk;

    regfile_sweep #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .clr_req_i(clr), .busy_o(busy_a),
        .rd_addr1_i(ra1), .rd_addr2_i(ra2), .rd_data1_o(r1_a), .rd_data2_o(r2_a),
        .we_i(we), .wr_addr_i(wa), .wr_data_i(wd), .wr_err_o(err_a)
    );

    regfile_sweep #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .clr_req_i(clr), .busy_o(busy_b),
        .rd_addr1_i(ra1), .rd_addr2_i(ra2), .rd_data1_o(r1_b), .rd_data2_o(r2_b),
        .we_i(we), .wr_addr_i(wa), .wr_data_i(wd), .wr_err_o(err_b)
    );

    logic       o_busy [2];
    logic       o_err  [2];
    logic [7:0] o_r1   [2];
    logic [7:0] o_r2   [2];
    assign o_busy[0] = busy_a; assign o_busy[1] = busy_b;
    assign o_err[0]  = err_a;  assign o_err[1]  = err_b;
    assign o_r1[0]   = r1_a;   assign o_r1[1]   = r1_b;
    assign o_r2[0]   = r2_a;   assign o_r2[1]   = r2_b;

    // ---------------- reference model ----------------
    int unsigned DEP [2] = '{8, 6};
    bit          ZR  [2] = '{1'b1, 1'b0};
    bit          BP  [2] = '{1'b1, 1'b0};

    logic [7:0] mm [2][8];
    int         clr_left [2];
    logic [7:0] e_r1 [2];
    logic [7:0] e_r2 [2];
    bit         e_busy [2];
    bit         e_err  [2];

    int n_vec = 0;
    int n_bad = 0;

    // A sweep makes the whole file read zero once it finishes, and nothing
    // inside it is observable, so the model zeroes its array up front.
    task automatic model_reset(int k);
        for (int a = 0; a < 8; a++) mm[k][a] = 8'h00;
        clr_left[k] = int'(DEP[k]);
        e_r1[k]   = 8'h00;
        e_r2[k]   = 8'h00;
        e_busy[k] = 1'b1;
        e_err[k]  = 1'b0;
    endtask

    function automatic logic [7:0] rd_model(int k, logic [2:0] ra, bit clearing, bit acc);
        if (clearing) return 8'h00;
        if (int'(ra) >= int'(DEP[k]) || (ZR[k] && ra == 3'd0)) return 8'h00;
        if (BP[k] && acc && wa == ra) return wd;
        return mm[k][ra];
    endfunction

    task automatic model_step(int k);
        bit clearing;
        bit acc;
        if (rst) begin
            model_reset(k);
            return;
        end
        clearing = (clr_left[k] != 0);
        acc = !clearing && we && (int'(wa) < int'(DEP[k])) && !(ZR[k] && wa == 3'd0);
        e_err[k] = we && (clearing || int'(wa) >= int'(DEP[k]));
        e_r1[k]  = rd_model(k, ra1, clearing, acc);
        e_r2[k]  = rd_model(k, ra2, clearing, acc);
        if (acc) mm[k][wa] = wd;
        if (clearing) begin
            clr_left[k]--;
        end else if (clr) begin
            clr_left[k] = int'(DEP[k]);
            for (int a = 0; a < 8; a++) mm[k][a] = 8'h00;
        end
        e_busy[k] = (clr_left[k] != 0);
    endtask

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy[%0d]", k), {7'd0, o_busy[k]}, {7'd0, e_busy[k]});
            chk($sformatf("wr_err[%0d]", k), {7'd0, o_err[k]}, {7'd0, e_err[k]});
            chk($sformatf("rd_data1[%0d]", k), o_r1[k], e_r1[k]);
            chk($sformatf("rd_data2[%0d]", k), o_r2[k], e_r2[k]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            ra2 = 3'(7 - a);
            cycle();
        end
    endtask

    task automatic fill();
        for (int a = 1; a < 8; a++) begin
            we = 1'b1;
            wa = 3'(a);
            wd = 8'(a * 8'h11);
            cycle();
        end
        we = 1'b0;
    endtask

    task automatic count_busy(output int na, output int nb, input bit inject_wr);
        na = 0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (inject_wr && i == 3) begin
                we = 1'b1; wa = 3'd2; wd = 8'h99;
            end
            cycle();
            if (inject_wr && i == 3) begin
                chk("sweep_wr_err_a", {7'd0, err_a}, 8'd1);
                chk("sweep_wr_err_b", {7'd0, err_b}, 8'd1);
                we = 1'b0;
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [7:0] a1;
        logic [7:0] a2;
        logic       aerr;
        logic [7:0] b2;
        logic       berr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int na, nb;

        //            we wa wd     ra1 ra2  a1     a2     aerr b2     berr
        tbl[0] = '{1'b1, 3'd3, 8'hA5, 3'd1, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5, 1'b0, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 3'd5, 8'h3C, 3'd0, 3'd5, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd5, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0};
        tbl[4] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0};
        tbl[6] = '{1'b1, 3'd7, 8'h11, 3'd7, 3'd7, 8'h11, 8'h11, 1'b0, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd7, 8'h11, 8'h11, 1'b0, 8'h00, 1'b0};

        // Reset: asynchronous assertion is visible before any clock edge.
        #2 rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1 check_all();
        cycle();
        cycle();
        #2 rst = 1'b0;

        // Post-reset sweep length, then everything reads zero.
        count_busy(na, nb, 1'b0);
        chk("reset_sweep_len_a", 8'(na), 8'd8);
        chk("reset_sweep_len_b", 8'(nb), 8'd6);
        read_all();

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
            ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            cycle();
            chk($sformatf("tbl%0d_a_rd1", i), r1_a, tbl[i].a1);
            chk($sformatf("tbl%0d_a_rd2", i), r2_a, tbl[i].a2);
            chk($sformatf("tbl%0d_a_err", i), {7'd0, err_a}, {7'd0, tbl[i].aerr});
            chk($sformatf("tbl%0d_b_rd2", i), r2_b, tbl[i].b2);
            chk($sformatf("tbl%0d_b_err", i), {7'd0, err_b}, {7'd0, tbl[i].berr});
        end
        we = 1'b0;

        // Clear sweep with a write dropped mid-sweep.
        fill();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        count_busy(na, nb, 1'b1);
        chk("clr_sweep_len_a", 8'(na), 8'd8);
        chk("clr_sweep_len_b", 8'(nb), 8'd6);
        read_all();
        chk("after_clr_rd_a", r1_a, 8'h00);

        // Reset in the middle of a sweep restarts it from the beginning.
        fill();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle(); cycle(); cycle();
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1 check_all();
        cycle();
        #2 rst = 1'b0;
        count_busy(na, nb, 1'b0);
        chk("restart_sweep_len_a", 8'(na), 8'd8);
        chk("restart_sweep_len_b", 8'(nb), 8'd6);
        read_all();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 3'($urandom);
            wd  = 8'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
            clr = ($urandom_range(0, 40) == 0);
            cycle();
        end
        clr = 1'b0;
        we  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
